// File: rtl/decode_stage.sv
// RV64I decode stage: F->D register, 32x64 register file with write-through,
// immediate generation and load-use hazard detection (one bubble per pair).
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   pc_F, inst_F     fetch pc / instruction; valid_F marks a real instruction
//   jb               taken jump/branch from E, flushes D to a bubble
//   wb_en/rd/data    register-file write port from WB
//   current_pc_D, inst_D, valid_D   contents of the F->D register
//   rs1_data_D, rs2_data_D, sext_imm_D   decoded operands
//   stall            load-use hazard: hold F and D, bubble E
module decode_stage #(
   parameter int unsigned      XLEN     = 64,
   parameter logic [31:0]      NOP_INST = 32'h0000_0013,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_F,
   input  logic [31:0]     inst_F,
   input  logic            valid_F,
   input  logic            jb,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] current_pc_D,
   output logic [31:0]     inst_D,
   output logic            valid_D,
   output logic [XLEN-1:0] rs1_data_D,
   output logic [XLEN-1:0] rs2_data_D,
   output logic [XLEN-1:0] sext_imm_D,
   output logic            stall
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;

   logic [XLEN-1:0] pc_q;
   logic [31:0]     inst_q;
   logic            valid_q;
   logic [XLEN-1:0] rf [32];
   logic            ld_valid_E;
   logic [4:0]      ld_rd_E;

   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   logic       wr_act;

   assign opcode = inst_q[6:0];
   assign rd     = inst_q[11:7];
   assign rs1    = inst_q[19:15];
   assign rs2    = inst_q[24:20];
   assign wr_act = wb_en && (wb_rd != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else if (jb) begin
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else if (!stall) begin
         pc_q    <= pc_F;
         inst_q  <= inst_F;
         valid_q <= valid_F;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (wr_act) begin
         rf[wb_rd] <= wb_data;
      end
   end

   // Tracks whether the instruction entering E is a load with a live rd.
   // A stall cycle sends a bubble to E, so the tracker clears then.
   always_ff @(posedge clk) begin
      if (rst || jb || stall) begin
         ld_valid_E <= 1'b0;
         ld_rd_E    <= '0;
      end else begin
         ld_valid_E <= valid_q && (opcode == OP_LOAD) && (rd != 5'd0);
         ld_rd_E    <= rd;
      end
   end

   // Write-through so WB and D can share a cycle without forwarding in E.
   always_comb begin
      rs1_data_D = rf[rs1];
      if (rs1 == 5'd0)
         rs1_data_D = '0;
      else if (wr_act && wb_rd == rs1)
         rs1_data_D = wb_data;
   end

   always_comb begin
      rs2_data_D = rf[rs2];
      if (rs2 == 5'd0)
         rs2_data_D = '0;
      else if (wr_act && wb_rd == rs2)
         rs2_data_D = wb_data;
   end

   logic is_i, is_s, is_b, is_u, is_j;

   assign is_i = (opcode == OP_LOAD) || (opcode == OP_IMM) ||
                 (opcode == OP_IMM32) || (opcode == OP_JALR);
   assign is_s = (opcode == OP_STORE);
   assign is_b = (opcode == OP_BRANCH);
   assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
   assign is_j = (opcode == OP_JAL);

   always_comb begin
      sext_imm_D = '0;
      unique case (1'b1)
         is_i: sext_imm_D = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
         is_s: sext_imm_D = {{(XLEN-12){inst_q[31]}},
                             inst_q[31:25], inst_q[11:7]};
         is_b: sext_imm_D = {{(XLEN-13){inst_q[31]}}, inst_q[31],
                             inst_q[7], inst_q[30:25],
                             inst_q[11:8], 1'b0};
         is_u: sext_imm_D = {{(XLEN-32){inst_q[31]}},
                             inst_q[31:12], 12'b0};
         is_j: sext_imm_D = {{(XLEN-21){inst_q[31]}}, inst_q[31],
                             inst_q[19:12], inst_q[20],
                             inst_q[30:21], 1'b0};
         default: sext_imm_D = '0;
      endcase
   end

   logic uses_rs1, uses_rs2;

   assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                       (opcode == OP_JAL));
   assign uses_rs2 = (opcode == OP_OP) || (opcode == OP_OP32) ||
                     is_s || is_b;

   // ld_rd_E is never x0 while ld_valid_E is set, so x0 reads never stall.
   assign stall = valid_q && ld_valid_E && !jb &&
                  ((uses_rs1 && rs1 == ld_rd_E) ||
                   (uses_rs2 && rs2 == ld_rd_E));

   assign current_pc_D = pc_q;
   assign inst_D       = inst_q;
   assign valid_D      = valid_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_F;
   logic [31:0] inst_F;
   logic        valid_F;
   logic        jb;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic [63:0] current_pc_D;
   logic [31:0] inst_D;
   logic        valid_D;
   logic [63:0] rs1_data_D;
   logic [63:0] rs2_data_D;
   logic [63:0] sext_imm_D;
   logic        stall;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ADD6  = 32'h0002_8333; // add x6,x5,x0
   localparam logic [31:0] ADDI1 = 32'h0000_0093; // addi x1,x0,0
   localparam logic [31:0] LD7   = 32'h0000_B383; // ld x7,0(x1)
   localparam logic [31:0] ADD8  = 32'h0023_8433; // add x8,x7,x2
   localparam logic [31:0] ADDI9 = 32'h0010_0493; // addi x9,x0,1
   localparam logic [31:0] LD0   = 32'h0000_B003; // ld x0,0(x1)
   localparam logic [31:0] ADDX0 = 32'h0020_0433; // add x8,x0,x2
   localparam logic [31:0] LD9   = 32'h0003_B483; // ld x9,0(x7)
   localparam logic [31:0] ADD10 = 32'h0004_8533; // add x10,x9,x0

   always #5 clk = ~clk;

   decode_stage dut (
      .clk          (clk),
      .rst          (rst),
      .pc_F         (pc_F),
      .inst_F       (inst_F),
      .valid_F      (valid_F),
      .jb           (jb),
      .wb_en        (wb_en),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .current_pc_D (current_pc_D),
      .inst_D       (inst_D),
      .valid_D      (valid_D),
      .rs1_data_D   (rs1_data_D),
      .rs2_data_D   (rs2_data_D),
      .sext_imm_D   (sext_imm_D),
      .stall        (stall)
   );

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic feed(input logic [63:0] pc, input logic [31:0] inst);
      pc_F    = pc;
      inst_F  = inst;
      valid_F = 1'b1;
   endtask

   task automatic imm_case(input string tag, input logic [31:0] inst,
                           input logic [63:0] exp);
      feed(64'h200, inst);
      tick();
      settle();
      check(tag, sext_imm_D, exp);
   endtask

   initial begin
      rst = 1'b1; pc_F = '0; inst_F = '0; valid_F = 1'b0;
      jb = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
      tick();
      tick();
      rst = 1'b0;
      settle();
      // reset state
      check("rst_inst", 64'(inst_D), 64'(NOP));
      check("rst_valid", 64'(valid_D), 64'd0);
      check("rst_pc", current_pc_D, 64'd0);
      check("rst_rs1", rs1_data_D, 64'd0);
      check("rst_rs2", rs2_data_D, 64'd0);
      check("rst_imm", sext_imm_D, 64'd0);
      check("rst_stall", 64'(stall), 64'd0);

      // write-through and x0
      feed(64'h10, ADD6);
      tick();
      wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEADBEEF00000001;
      settle();
      check("wt_rs1", rs1_data_D, 64'hDEADBEEF00000001);
      check("wt_rs2_x0", rs2_data_D, 64'd0);
      check("wt_pc", current_pc_D, 64'h10);
      tick();
      wb_en = 1'b0;
      settle();
      check("rf_rs1", rs1_data_D, 64'hDEADBEEF00000001);
      feed(64'h14, ADDI1);
      wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
      tick();
      settle();
      check("x0_wt", rs1_data_D, 64'd0);
      tick();
      wb_en = 1'b0;
      settle();
      check("x0_rd", rs1_data_D, 64'd0);

      // immediates
      imm_case("imm_i", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF);
      imm_case("imm_b", 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC);
      imm_case("imm_lui", 32'h800000B7, 64'hFFFFFFFF80000000);
      imm_case("imm_jal", 32'h0000006F, 64'd0);
      imm_case("imm_s", 32'hFE20BC23, 64'hFFFFFFFFFFFFFFF8);
      imm_case("imm_auipc", 32'h12345097, 64'h0000000012345000);
      imm_case("imm_r", ADD8, 64'd0);

      // load-use: one stall cycle, D held
      feed(64'h100, LD7);
      tick();
      settle();
      check("ld_nostall", 64'(stall), 64'd0);
      feed(64'h104, ADD8);
      tick();
      feed(64'h108, ADDI9);
      settle();
      check("lu_stall", 64'(stall), 64'd1);
      check("lu_inst", 64'(inst_D), 64'(ADD8));
      tick();
      settle();
      check("lu_hold_inst", 64'(inst_D), 64'(ADD8));
      check("lu_hold_pc", current_pc_D, 64'h104);
      check("lu_once", 64'(stall), 64'd0);
      tick();
      settle();
      check("lu_adv_pc", current_pc_D, 64'h108);
      check("lu_adv_stall", 64'(stall), 64'd0);

      // load to x0 never stalls
      feed(64'h10C, LD0);
      tick();
      feed(64'h110, ADDX0);
      tick();
      settle();
      check("ldx0_stall", 64'(stall), 64'd0);
      check("ldx0_pc", current_pc_D, 64'h110);

      // back-to-back dependent loads
      feed(64'h120, LD7);
      tick();
      feed(64'h124, LD9);
      tick();
      feed(64'h128, ADD10);
      settle();
      check("b2b_st1", 64'(stall), 64'd1);
      tick();
      settle();
      check("b2b_hold1", 64'(stall), 64'd0);
      check("b2b_hold1_pc", current_pc_D, 64'h124);
      tick();
      feed(64'h12C, NOP);
      settle();
      check("b2b_st2", 64'(stall), 64'd1);
      check("b2b_st2_pc", current_pc_D, 64'h128);
      tick();
      settle();
      check("b2b_rel2", 64'(stall), 64'd0);
      check("b2b_rel2_pc", current_pc_D, 64'h128);

      // flush wins over stall
      feed(64'h140, LD7);
      tick();
      feed(64'h144, ADD8);
      tick();
      settle();
      check("jb_pre_stall", 64'(stall), 64'd1);
      jb = 1'b1;
      settle();
      check("jb_stall0", 64'(stall), 64'd0);
      tick();
      jb = 1'b0;
      settle();
      check("jb_inst", 64'(inst_D), 64'(NOP));
      check("jb_valid", 64'(valid_D), 64'd0);
      check("jb_pc", current_pc_D, 64'd0);
      check("jb_stall", 64'(stall), 64'd0);

      // reset during stall
      wb_en = 1'b1; wb_rd = 5'd2; wb_data = 64'h55;
      tick();
      wb_en = 1'b0;
      feed(64'h160, LD7);
      tick();
      feed(64'h164, ADD8);
      tick();
      settle();
      check("rs_pre_stall", 64'(stall), 64'd1);
      check("rs_pre_rs2", rs2_data_D, 64'h55);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      valid_F = 1'b0;
      settle();
      check("rs_stall", 64'(stall), 64'd0);
      check("rs_pc", current_pc_D, 64'd0);
      check("rs_inst", 64'(inst_D), 64'(NOP));
      feed(64'h180, ADD6);
      tick();
      settle();
      check("rs_x5", rs1_data_D, 64'd0);
      feed(64'h184, ADD8);
      tick();
      settle();
      check("rs_x2", rs2_data_D, 64'd0);
      check("rs_nostall", 64'(stall), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
